// File: rtl/sfq_drv_pkg.sv
// Shared types and constants for the SFQ AND2 stimulus driver.
// The CHECK state exists only when SFQ_DRV_CHECK_EN is defined.
package sfq_drv_pkg;

  localparam int unsigned SFQ_DRV_CW        = 4;
  localparam int unsigned SFQ_DRV_CYC_MAX   = (1 << SFQ_DRV_CW) - 1;
  localparam int unsigned SFQ_DRV_SETUP_DEF = 2;
  localparam int unsigned SFQ_DRV_HOLD_DEF  = 2;
  localparam int unsigned SFQ_DRV_QWAIT_DEF = 6;

  localparam logic [1:0]  SFQ_TGL_CNT_MAX   = 2'd3;
  localparam logic [7:0]  SFQ_ERR_CNT_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HOLD  = 2'd2
`ifdef SFQ_DRV_CHECK_EN
    , CHECK = 2'd3
`endif
  } sfq_drv_state_t;

  // Counters count down to zero, so an N-cycle interval loads N-1.
  function automatic logic [SFQ_DRV_CW-1:0] cyc_load(input int unsigned cyc);
    return SFQ_DRV_CW'(cyc - 1);
  endfunction

endpackage

// File: rtl/sfq_toggle_detect.sv
// Registers a toggle-encoded line, flags each transition and counts
// transitions in a 2-bit saturating window counter (clr wins over en).
module sfq_toggle_detect
  import sfq_drv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       line,
  input  logic       clr,
  input  logic       en,
  output logic       pulse,
  output logic [1:0] cnt
);

  logic       line_q;
  logic [1:0] cnt_q;

  assign pulse = line ^ line_q;
  assign cnt   = cnt_q;

  // NOTE: sequential state uses <= so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      line_q <= line;
      if (clr) begin
        cnt_q <= '0;
      end else if (en && pulse && (cnt_q != SFQ_TGL_CNT_MAX)) begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

endmodule

// File: rtl/sfq_and2_driver.sv
// Toggle-encoded stimulus driver for a clocked SFQ AND2 gate with setup/hold spacing.
// Define SFQ_DRV_CHECK_EN to compile in the q_in result checker and CHECK state.
module sfq_and2_driver
  import sfq_drv_pkg::*;
#(
  parameter int unsigned SETUP_CYC  = SFQ_DRV_SETUP_DEF,
  parameter int unsigned HOLD_CYC   = SFQ_DRV_HOLD_DEF,
  parameter int unsigned Q_WAIT_CYC = SFQ_DRV_QWAIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_a,
  input  logic       req_b,
  output logic       req_ready,
  output logic       sfq_a,
  output logic       sfq_b,
  output logic       sfq_clk,
  output logic       busy,
  input  logic       q_in,
  output logic       err_q,
  output logic [7:0] err_cnt
);

  if (SETUP_CYC < 1 || SETUP_CYC > SFQ_DRV_CYC_MAX) begin : g_bad_setup
    $error("SETUP_CYC must be in 1..15");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > SFQ_DRV_CYC_MAX) begin : g_bad_hold
    $error("HOLD_CYC must be in 1..15");
  end
  if (Q_WAIT_CYC < 1 || Q_WAIT_CYC > SFQ_DRV_CYC_MAX) begin : g_bad_qwait
    $error("Q_WAIT_CYC must be in 1..15");
  end

  localparam logic [SFQ_DRV_CW-1:0] SETUP_LD = cyc_load(SETUP_CYC);
  localparam logic [SFQ_DRV_CW-1:0] HOLD_LD  = cyc_load(HOLD_CYC);

  sfq_drv_state_t        state_q;
  logic [SFQ_DRV_CW-1:0] cnt_q;
  logic                  sfq_a_q, sfq_b_q, sfq_clk_q, ready_q;
  logic                  tgl_edge;

  assign tgl_edge  = (state_q == SETUP) && (cnt_q == '0);
  assign req_ready = ready_q;
  assign busy      = ~ready_q;
  assign sfq_a     = sfq_a_q;
  assign sfq_b     = sfq_b_q;
  assign sfq_clk   = sfq_clk_q;

`ifdef SFQ_DRV_CHECK_EN
  localparam logic [SFQ_DRV_CW-1:0] QWAIT_LD = cyc_load(Q_WAIT_CYC);

  logic                  exp_q, win_q, win_end, tgl_pulse, err_q_q, err_d;
  logic [SFQ_DRV_CW-1:0] wcnt_q;
  logic [1:0]            tgl_cnt;
  logic [2:0]            q_total;
  logic [7:0]            err_cnt_q;

  assign win_end = win_q && (wcnt_q == '0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sfq_a_q   <= 1'b0;
      sfq_b_q   <= 1'b0;
      sfq_clk_q <= 1'b0;
      ready_q   <= 1'b1;
`ifdef SFQ_DRV_CHECK_EN
      exp_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (req_valid) begin
          sfq_a_q <= sfq_a_q ^ req_a;
          sfq_b_q <= sfq_b_q ^ req_b;
`ifdef SFQ_DRV_CHECK_EN
          exp_q   <= req_a & req_b;
`endif
          cnt_q   <= SETUP_LD;
          ready_q <= 1'b0;
          state_q <= SETUP;
        end
        SETUP: if (tgl_edge) begin
          sfq_clk_q <= ~sfq_clk_q;
          cnt_q     <= HOLD_LD;
          state_q   <= HOLD;
        end else begin
          cnt_q <= cnt_q - SFQ_DRV_CW'(1);
        end
        HOLD: if (cnt_q == '0) begin
`ifdef SFQ_DRV_CHECK_EN
          // The observation window may outlast the hold interval.
          if (win_q && !win_end) begin
            state_q <= CHECK;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
`else
          state_q <= IDLE;
          ready_q <= 1'b1;
`endif
        end else begin
          cnt_q <= cnt_q - SFQ_DRV_CW'(1);
        end
`ifdef SFQ_DRV_CHECK_EN
        CHECK: if (win_end) begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
`endif
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef SFQ_DRV_CHECK_EN
  sfq_toggle_detect u_q_det (
    .clk   (clk),
    .rst   (rst),
    .line  (q_in),
    .clr   (tgl_edge),
    .en    (win_q),
    .pulse (tgl_pulse),
    .cnt   (tgl_cnt)
  );

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    err_d   = 1'b0;
    q_total = {1'b0, tgl_cnt} + {2'b00, tgl_pulse};
    if (win_end && (q_total != {2'b00, exp_q})) begin
      err_d = 1'b1;
    end
    if (tgl_pulse && !win_q) begin
      err_d = 1'b1;
    end
  end

  // Window covers the Q_WAIT_CYC edges following the gate-clock toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q     <= 1'b0;
      wcnt_q    <= '0;
      err_q_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (tgl_edge) begin
        win_q  <= 1'b1;
        wcnt_q <= QWAIT_LD;
      end else if (win_end) begin
        win_q <= 1'b0;
      end else if (win_q) begin
        wcnt_q <= wcnt_q - SFQ_DRV_CW'(1);
      end
      err_q_q <= err_d;
      if (err_d && (err_cnt_q != SFQ_ERR_CNT_MAX)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign err_q   = err_q_q;
  assign err_cnt = err_cnt_q;
`else
  logic unused_q_in;
  assign unused_q_in = q_in;
  assign err_q       = 1'b0;
  assign err_cnt     = '0;
`endif

endmodule
